// File: rtl/fp16_pkg.sv
// Shared binary16 constants and field layout for the int/fp conversion datapath.
package fp16_pkg;

  localparam int          FP16_BIAS    = 15;
  localparam int          FP16_EXP_W   = 5;
  localparam int          FP16_FRAC_W  = 10;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp_int2fp.sv
// Combinational unsigned 16-bit integer to binary16 converter, round to nearest-even.
module fp_int2fp
  import fp16_pkg::*;
(
  input  logic [15:0] i_int,
  output fp16_t       o_fp,
  output logic        o_inexact
);

  logic [3:0]  w_pos;
  logic [15:0] w_norm;
  logic        w_nonzero;
  logic        w_guard;
  logic        w_sticky;
  logic        w_rnd_up;
  logic [10:0] w_frac_sum;
  logic [4:0]  w_exp;

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_int[i]) w_pos = 4'(i);
    end
  end

  // Left-justify so the leading one sits at bit 15; zero input stays zero.
  assign w_norm    = i_int << (4'd15 - w_pos);
  assign w_nonzero = w_norm[15];
  assign w_guard   = w_norm[4];
  assign w_sticky  = |w_norm[3:0];
  assign w_rnd_up  = w_guard & (w_sticky | w_norm[5]);

  // Carry out of the fraction bumps the exponent; the fraction wraps to zero.
  assign w_frac_sum = {1'b0, w_norm[14:5]} + 11'(w_rnd_up);
  assign w_exp      = 5'(w_pos) + 5'(FP16_BIAS) + 5'(w_frac_sum[10]);

  always_comb begin
    o_fp      = '0;
    o_inexact = 1'b0;
    if (w_nonzero) begin
      o_inexact = w_guard | w_sticky;
      if (w_exp == 5'd31) begin
        o_fp = FP16_POS_INF;
      end else begin
        o_fp.exp  = w_exp;
        o_fp.frac = w_frac_sum[9:0];
      end
    end
  end

endmodule

// File: rtl/fp_fp2int.sv
// Two-lane registered converter: unsigned int -> binary16 (RNE) and binary16 -> unsigned int
// (truncate, saturate). Both lanes share one valid and one output register stage.
module fp_fp2int
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] int_in,
  input  logic [15:0] fp_in,
  output logic        out_valid,
  output logic [15:0] fp_out,
  output logic [15:0] int_out,
  output logic        fp_inexact,
  output logic        int_sat
);

  fp16_t       w_fp_res;
  logic        w_fp_inexact;
  fp16_t       w_fp_in;
  logic [3:0]  w_e;
  logic [15:0] w_sig;
  logic [15:0] w_int_res;
  logic        w_int_sat;

  logic        r_valid;
  logic [15:0] r_fp_out;
  logic [15:0] r_int_out;
  logic        r_fp_inexact;
  logic        r_int_sat;

  fp_int2fp u_int2fp (
    .i_int     (int_in),
    .o_fp      (w_fp_res),
    .o_inexact (w_fp_inexact)
  );

  assign w_fp_in = fp_in;
  // Unbiased exponent; only consulted once exp >= bias, so it lands in 0..15.
  assign w_e     = 4'(w_fp_in.exp - 5'(FP16_BIAS));
  assign w_sig   = {5'b0, 1'b1, w_fp_in.frac};

  always_comb begin
    w_int_res = '0;
    w_int_sat = 1'b0;
    if (w_fp_in.exp == 5'd31) begin
      w_int_sat = 1'b1;
      w_int_res = w_fp_in.sign ? 16'h0000 : 16'hFFFF;
    end else if (w_fp_in.exp >= 5'(FP16_BIAS)) begin
      if (w_fp_in.sign) begin
        w_int_sat = 1'b1;
      end else if (w_e <= 4'd10) begin
        w_int_res = w_sig >> (4'd10 - w_e);
      end else begin
        w_int_res = w_sig << (w_e - 4'd10);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_fp_out     <= '0;
      r_int_out    <= '0;
      r_fp_inexact <= 1'b0;
      r_int_sat    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_fp_out     <= w_fp_res;
        r_int_out    <= w_int_res;
        r_fp_inexact <= w_fp_inexact;
        r_int_sat    <= w_int_sat;
      end
    end
  end

  assign out_valid  = r_valid;
  assign fp_out     = r_fp_out;
  assign int_out    = r_int_out;
  assign fp_inexact = r_fp_inexact;
  assign int_sat    = r_int_sat;

endmodule

// File: tb/tb_fp_fp2int.sv
// Self-checking bench for fp_fp2int: arithmetic reference model, directed literals, random traffic.
module tb_fp_fp2int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] int_in = '0;
  logic [15:0] fp_in = '0;
  logic        out_valid;
  logic [15:0] fp_out;
  logic [15:0] int_out;
  logic        fp_inexact;
  logic        int_sat;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  logic        m_valid = 1'b0;
  logic [15:0] m_fp = '0;
  logic [15:0] m_int = '0;
  logic        m_inx = 1'b0;
  logic        m_sat = 1'b0;

  fp_fp2int dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .int_in     (int_in),
    .fp_in      (fp_in),
    .out_valid  (out_valid),
    .fp_out     (fp_out),
    .int_out    (int_out),
    .fp_inexact (fp_inexact),
    .int_sat    (int_sat)
  );

  always #5 clk = ~clk;

  // Reference int -> fp: round the integer to the nearest representable value, then encode it.
  function automatic logic [16:0] m_i2f(input logic [15:0] x);
    longint v, ulp, q, r, rr;
    int p, e;
    v = longint'(x);
    p = 0;
    e = 0;
    if (v == 0) return 17'h0;
    while ((v >> (p + 1)) != 0) p++;
    if (p <= 10) begin
      rr = v;
    end else begin
      ulp = longint'(1) << (p - 10);
      q = v / ulp;
      r = v % ulp;
      if ((r * 2 > ulp) || ((r * 2 == ulp) && (q % 2 == 1))) q++;
      rr = q * ulp;
    end
    if (rr > 65504) return {1'b1, 16'h7C00};
    while ((rr >> (e + 1)) != 0) e++;
    return {(rr != v), 1'b0, 5'(e + 15), 10'(((rr << 10) >> e) - 1024)};
  endfunction

  // Reference fp -> int: value = (1024+frac) * 2^(exp-25), truncated; clamps as described.
  function automatic logic [16:0] m_f2i(input logic [15:0] h);
    longint m;
    logic [4:0] ex;
    ex = h[14:10];
    if (ex == 5'd31) return h[15] ? {1'b1, 16'h0000} : {1'b1, 16'hFFFF};
    if (ex == 5'd0) m = 0;
    else m = ((longint'(1024) + longint'(h[9:0])) << ex) >> 25;
    if (h[15]) return {(m != 0), 16'h0000};
    return {1'b0, 16'(m)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_fp    <= '0;
      m_int   <= '0;
      m_inx   <= 1'b0;
      m_sat   <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        {m_inx, m_fp}  <= m_i2f(int_in);
        {m_sat, m_int} <= m_f2i(fp_in);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model out_valid", 16'(out_valid), 16'(m_valid));
      check("model fp_out", fp_out, m_fp);
      check("model fp_inexact", 16'(fp_inexact), 16'(m_inx));
      check("model int_out", int_out, m_int);
      check("model int_sat", 16'(int_sat), 16'(m_sat));
    end
  end

  typedef struct packed {
    logic [15:0] iv;
    logic [15:0] efp;
    logic        einx;
    logic [15:0] fv;
    logic [15:0] eint;
    logic        esat;
  } vec_t;

  vec_t dirq[$];

  task automatic lit_check(input vec_t t, input logic exp_valid);
    check("lit out_valid", 16'(out_valid), 16'(exp_valid));
    check($sformatf("lit fp_out(%0d)", t.iv), fp_out, t.efp);
    check($sformatf("lit fp_inexact(%0d)", t.iv), 16'(fp_inexact), 16'(t.einx));
    check($sformatf("lit int_out(%h)", t.fv), int_out, t.eint);
    check($sformatf("lit int_sat(%h)", t.fv), 16'(int_sat), 16'(t.esat));
  endtask

  initial begin
    vec_t last;
    vec_t rv;
    dirq.push_back('{16'd1,     16'h3C00, 1'b0, 16'h3C00, 16'd1,     1'b0});
    dirq.push_back('{16'd17,    16'h4C40, 1'b0, 16'h4C40, 16'd17,    1'b0});
    dirq.push_back('{16'd256,   16'h5C00, 1'b0, 16'h5C00, 16'd256,   1'b0});
    dirq.push_back('{16'd12343, 16'h7207, 1'b1, 16'h7207, 16'd12344, 1'b0});
    dirq.push_back('{16'd18343, 16'h747A, 1'b1, 16'h747A, 16'd18336, 1'b0});
    dirq.push_back('{16'd32343, 16'h77E5, 1'b1, 16'h77E5, 16'd32336, 1'b0});
    dirq.push_back('{16'd65535, 16'h7C00, 1'b1, 16'h7C00, 16'hFFFF,  1'b1});
    dirq.push_back('{16'd65504, 16'h7BFF, 1'b0, 16'h7BFF, 16'd65504, 1'b0});
    dirq.push_back('{16'd65520, 16'h7C00, 1'b1, 16'h3800, 16'd0,     1'b0});
    dirq.push_back('{16'd65519, 16'h7BFF, 1'b1, 16'h3E00, 16'd1,     1'b0});
    dirq.push_back('{16'd2048,  16'h6800, 1'b0, 16'hBC00, 16'd0,     1'b1});
    dirq.push_back('{16'd2049,  16'h6800, 1'b1, 16'h7E00, 16'hFFFF,  1'b1});
    dirq.push_back('{16'd2051,  16'h6802, 1'b1, 16'h0001, 16'd0,     1'b0});
    dirq.push_back('{16'd0,     16'h0000, 1'b0, 16'hFC00, 16'd0,     1'b1});
    dirq.push_back('{16'd3,     16'h4200, 1'b0, 16'h8000, 16'd0,     1'b0});
    dirq.push_back('{16'd1023,  16'h63FE, 1'b0, 16'hB800, 16'd0,     1'b0});
    dirq.push_back('{16'd4097,  16'h6C00, 1'b1, 16'h6401, 16'd1025,  1'b0});

    // Reset state, asserted from time zero.
    #3;
    check("reset out_valid", 16'(out_valid), 16'd0);
    check("reset fp_out", fp_out, 16'd0);
    check("reset int_out", int_out, 16'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed vectors, back-to-back at one result per cycle.
    last = dirq[0];
    foreach (dirq[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      int_in   = dirq[i].iv;
      fp_in    = dirq[i].fv;
      @(posedge clk);
      #1;
      lit_check(dirq[i], 1'b1);
      last = dirq[i];
    end

    // Outputs hold while in_valid is low, whatever the operands do.
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int_in = 16'($urandom);
      fp_in  = 16'($urandom);
      @(posedge clk);
      #1;
      lit_check(last, 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream.
    rv = dirq[3];
    in_valid = 1'b1;
    int_in   = rv.iv;
    fp_in    = 16'h7C00;
    @(posedge clk);
    @(negedge clk);
    int_in = 16'd65535;
    @(posedge clk);
    #1;
    check("pre-reset fp_out", fp_out, 16'h7C00);
    check("pre-reset int_sat", 16'(int_sat), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 16'(out_valid), 16'd0);
    check("async reset fp_out", fp_out, 16'd0);
    check("async reset int_out", int_out, 16'd0);
    check("async reset fp_inexact", 16'(fp_inexact), 16'd0);
    check("async reset int_sat", 16'(int_sat), 16'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    in_valid = 1'b1;
    int_in   = rv.iv;
    fp_in    = rv.fv;
    @(posedge clk);
    #1;
    lit_check(rv, 1'b1);

    // Random traffic checked against the model on every cycle.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      int_in   = 16'($urandom) >> $urandom_range(0, 15);
      fp_in    = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
